// File: rtl/fp_divider_if.sv
// fp_divider_if: start/busy/done handshake, operands, result and exception flags of the FP divider
interface fp_divider_if #(
    parameter int FLEN = 32
);
    logic            start;
    logic [2:0]      rounding_mode;
    logic [FLEN-1:0] operand_a;
    logic [FLEN-1:0] operand_b;
    logic            busy;
    logic            done;
    logic [FLEN-1:0] result;
    logic            flag_nv;
    logic            flag_dz;
    logic            flag_of;
    logic            flag_uf;
    logic            flag_nx;

    modport master (
        output start, rounding_mode, operand_a, operand_b,
        input  busy, done, result, flag_nv, flag_dz, flag_of, flag_uf, flag_nx
    );

    modport slave (
        input  start, rounding_mode, operand_a, operand_b,
        output busy, done, result, flag_nv, flag_dz, flag_of, flag_uf, flag_nx
    );
endinterface

// File: rtl/fp_divider.sv
// fp_divider: multi-cycle IEEE 754 divider, radix-2 restoring mantissa division, RISC-V rounding and flags
module fp_divider #(
    parameter int FLEN = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    fp_divider_if.slave io
);
    localparam int EXP  = (FLEN == 64) ? 11 : 8;
    localparam int MAN  = (FLEN == 64) ? 52 : 23;
    localparam int BIAS = (1 << (EXP - 1)) - 1;
    localparam int MW   = MAN + 1;
    localparam int Q    = MAN + 4;
    localparam int EW   = EXP + 2;
    localparam int CW   = $clog2(Q);
    localparam logic [EW-1:0]   BIAS_E = EW'(BIAS);
    localparam logic [EW-1:0]   MAX_E  = EW'((1 << EXP) - 1);
    localparam logic [FLEN-1:0] QNAN   = {1'b0, {(EXP + 1){1'b1}}, {(MAN - 1){1'b0}}};
    localparam logic [2:0]      RTZ    = 3'b001;
    localparam logic [2:0]      RDN    = 3'b010;
    localparam logic [2:0]      RUP    = 3'b011;
    localparam logic [2:0]      RMM    = 3'b100;

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORMALIZE, ROUND, DONE} state_t;

    state_t          state_q, state_d;
    logic [FLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]      rm_q, rm_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic [MW:0]     rem_q, rem_d;
    logic [Q-1:0]    quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      flags_q, flags_d;

    // Operand classification; subnormals are read as zero
    logic [EXP-1:0]  ea, eb;
    logic [MAN-1:0]  fa, fb;
    logic            sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special, spec_nv, spec_dz;
    logic [FLEN-1:0] inf_s, zero_s, max_s, spec_res;
    assign ea       = a_q[FLEN-2:MAN];
    assign eb       = b_q[FLEN-2:MAN];
    assign fa       = a_q[MAN-1:0];
    assign fb       = b_q[MAN-1:0];
    assign sign     = a_q[FLEN-1] ^ b_q[FLEN-1];
    assign a_nan    = (&ea) & (|fa);
    assign b_nan    = (&eb) & (|fb);
    assign a_inf    = (&ea) & ~(|fa);
    assign b_inf    = (&eb) & ~(|fb);
    assign a_zero   = ~(|ea);
    assign b_zero   = ~(|eb);
    assign special  = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    assign inf_s    = {sign, {EXP{1'b1}}, {MAN{1'b0}}};
    assign zero_s   = {sign, {(FLEN - 1){1'b0}}};
    assign max_s    = {sign, {(EXP - 1){1'b1}}, 1'b0, {MAN{1'b1}}};
    assign spec_res = (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) ? QNAN :
                      a_inf ? inf_s : (b_inf | a_zero) ? zero_s : inf_s;
    assign spec_nv  = (a_nan & ~fa[MAN-1]) | (b_nan & ~fb[MAN-1]) | (a_zero & b_zero) | (a_inf & b_inf);
    assign spec_dz  = b_zero & ~(a_zero | a_inf | a_nan);

    // Divide step: trial subtraction of the divisor mantissa
    logic [MW:0] mb_ext;
    logic        ge, rem_nz;
    assign mb_ext = {2'b01, fb};
    assign ge     = rem_q >= mb_ext;
    assign rem_nz = |rem_q;

    // Rounding of the normalized quotient: {mantissa, G, R, S}
    logic [MW-1:0]  mant;
    logic [MW:0]    sum;
    logic [EW-1:0]  exp_r;
    logic [MAN-1:0] frac;
    logic           g, r, s, grs, inc, carry, uf, of, ovf_max;
    assign mant    = quo_q[Q-1:3];
    assign g       = quo_q[2];
    assign r       = quo_q[1];
    assign s       = quo_q[0];
    assign grs     = g | r | s;
    assign inc     = (rm_q == RTZ) ? 1'b0 : (rm_q == RDN) ? sign & grs : (rm_q == RUP) ? ~sign & grs :
                     (rm_q == RMM) ? g : g & (r | s | mant[0]);
    assign sum     = {1'b0, mant} + {{MW{1'b0}}, inc};
    assign carry   = sum[MW];
    assign exp_r   = exp_q + EW'(carry);
    assign frac    = carry ? sum[MAN:1] : sum[MAN-1:0];
    assign uf      = exp_q[EW-1] | (exp_q == '0);
    assign of      = exp_r >= MAX_E;
    assign ovf_max = (rm_q == RTZ) | ((rm_q == RDN) & ~sign) | ((rm_q == RUP) & sign);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rm_q    <= '0;
            exp_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rm_q    <= rm_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    // Next-state: specials short-circuit UNPACK straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = io.start ? UNPACK : IDLE;
            UNPACK:    state_d = special ? DONE : DIVIDE;
            DIVIDE:    state_d = (cnt_q == CW'(Q - 1)) ? NORMALIZE : DIVIDE;
            NORMALIZE: state_d = ROUND;
            ROUND:     state_d = DONE;
            default:   state_d = IDLE;
        endcase
    end

    // Datapath: latch, unpack, one quotient bit per cycle, normalize, round and pack
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        rm_d    = rm_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    a_d     = io.operand_a;
                    b_d     = io.operand_b;
                    rm_d    = io.rounding_mode;
                    flags_d = '0;
                end
            end
            UNPACK: begin
                exp_d = EW'(ea) - EW'(eb) + BIAS_E;
                rem_d = {2'b01, fa};
                quo_d = '0;
                cnt_d = '0;
                if (special) begin
                    res_d   = spec_res;
                    flags_d = {spec_nv, spec_dz, 3'b000};
                end
            end
            DIVIDE: begin
                rem_d = (ge ? rem_q - mb_ext : rem_q) << 1;
                quo_d = {quo_q[Q-2:0], ge};
                cnt_d = cnt_q + CW'(1);
            end
            NORMALIZE: begin
                quo_d = quo_q[Q-1] ? {quo_q[Q-1:1], quo_q[0] | rem_nz} : {quo_q[Q-2:0], rem_nz};
                exp_d = quo_q[Q-1] ? exp_q : exp_q - EW'(1);
            end
            ROUND: begin
                res_d   = uf ? zero_s : of ? (ovf_max ? max_s : inf_s) : {sign, exp_r[EXP-1:0], frac};
                flags_d = {2'b00, ~uf & of, uf, uf | of | grs};
            end
            default: ;
        endcase
    end

    // Outputs decoded from state and registered results
    always_comb begin
        io.busy    = (state_q != IDLE) && (state_q != DONE);
        io.done    = state_q == DONE;
        io.result  = res_q;
        io.flag_nv = flags_q[4];
        io.flag_dz = flags_q[3];
        io.flag_of = flags_q[2];
        io.flag_uf = flags_q[1];
        io.flag_nx = flags_q[0];
    end
endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed and randomized single-precision checks against an arithmetic reference model
module tb_fp_divider;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fp_divider_if #(.FLEN(32)) io ();

    fp_divider #(.FLEN(32)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .io     (io)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact quotient by wide integer division, then IEEE rounding rules; returns {nv,dz,of,uf,nx,result}
    function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        int          ea, eb, e, sh, m;
        bit          s, an, bn, ai, bi, az, bz, g, r, st, inc;
        logic [127:0] num, den, q, rem;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        az = ea == 0;
        bz = eb == 0;
        if (an || bn) return {(an && !a[22]) || (bn && !b[22]), 4'b0000, 32'h7FC00000};
        if ((az && bz) || (ai && bi)) return {5'b10000, 32'h7FC00000};
        if (ai) return {5'b00000, s, 31'h7F800000};
        if (bi || az) return {5'b00000, s, 31'h0};
        if (bz) return {5'b01000, s, 31'h7F800000};
        num = 128'({1'b1, a[22:0]}) << 40;
        den = 128'({1'b1, b[22:0]});
        q   = num / den;
        rem = num % den;
        sh  = q[40] ? 17 : 16;
        e   = ea - eb + 127 - (q[40] ? 0 : 1);
        m   = int'(q >> sh);
        g   = q[sh-1];
        r   = q[sh-2];
        st  = ((q & ((128'd1 << (sh - 2)) - 128'd1)) != 0) || (rem != 0);
        if (e < 1) return {5'b00011, s, 31'h0};
        case (rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = s && (g || r || st);
            3'd3:    inc = !s && (g || r || st);
            3'd4:    inc = g;
            default: inc = g && (r || st || m[0]);
        endcase
        m = m + int'(inc);
        if (m == (1 << 24)) begin
            m = 1 << 23;
            e++;
        end
        if (e >= 255)
            return {5'b00101, ((rm == 3'd1) || (rm == 3'd2 && !s) || (rm == 3'd3 && s)) ? {s, 31'h7F7FFFFF} : {s, 31'h7F800000}};
        return {4'b0000, g | r | st, s, 8'(e), 23'(m)};
    endfunction

    // Random operand biased toward normal values, with zeros, subnormals, infinities and NaNs mixed in
    function automatic logic [31:0] rnd_fp();
        int          k;
        logic [31:0] v;
        k = int'($urandom_range(0, 19));
        v = $urandom;
        if (k == 0) v[30:23] = 8'h00;
        else if (k == 1) v[30:23] = 8'hFF;
        else if (k == 2) v[30:0] = 31'h7F800000;
        else if (k >= 6) v[30:23] = 8'(127 + int'($urandom_range(0, 40)) - 20);
        return v;
    endfunction

    // One complete operation; poke re-asserts start with other operands mid-DIVIDE
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm, input bit poke,
                          output logic [36:0] got, output int lat);
        io.operand_a     = a;
        io.operand_b     = b;
        io.rounding_mode = rm;
        io.start         = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            io.start = poke && (lat == 5);
            if (poke && lat == 5) begin
                io.operand_a = 32'h3F800000;
                io.operand_b = 32'h40400000;
            end
        end while (!io.done && lat < 100);
        check("done_seen", io.done, 1'b1);
        got = {io.flag_nv, io.flag_dz, io.flag_of, io.flag_uf, io.flag_nx, io.result};
        @(posedge clk);
        #1;
        check("done_pulse", io.done, 1'b0);
        check("idle_busy", io.busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[$];
        logic [36:0] got, exp;
        logic [31:0] a, b;
        logic [2:0]  rm;
        int          lat, dones;

        io.start = 1'b0;
        io.operand_a = '0;
        io.operand_b = '0;
        io.rounding_mode = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", io.busy, 1'b0);
        check("rst_done", io.done, 1'b0);
        check("rst_result", io.result, 32'h0);
        check("rst_flags", {io.flag_nv, io.flag_dz, io.flag_of, io.flag_uf, io.flag_nx}, 5'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        vecs.push_back(vec_t'{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000, 31});
        vecs.push_back(vec_t'{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'b00001, 31});
        vecs.push_back(vec_t'{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'b00001, 31});
        vecs.push_back(vec_t'{32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 5'b00001, 31});
        vecs.push_back(vec_t'{32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 5'b00001, 31});
        vecs.push_back(vec_t'{32'h3F800000, 32'h40400000, 3'd5, 32'h3EAAAAAB, 5'b00001, 31});
        vecs.push_back(vec_t'{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'b01000, 2});
        vecs.push_back(vec_t'{32'hBF800000, 32'h00000000, 3'd0, 32'hFF800000, 5'b01000, 2});
        vecs.push_back(vec_t'{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000, 2});
        vecs.push_back(vec_t'{32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000, 2});
        vecs.push_back(vec_t'{32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b00000, 2});
        vecs.push_back(vec_t'{32'h7F000000, 32'h3E800000, 3'd0, 32'h7F800000, 5'b00101, 31});
        vecs.push_back(vec_t'{32'h7F000000, 32'h3E800000, 3'd1, 32'h7F7FFFFF, 5'b00101, 31});
        vecs.push_back(vec_t'{32'hFF000000, 32'h3E800000, 3'd3, 32'hFF7FFFFF, 5'b00101, 31});
        vecs.push_back(vec_t'{32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 5'b00011, 31});
        vecs.push_back(vec_t'{32'h80800000, 32'h40000000, 3'd0, 32'h80000000, 5'b00011, 31});
        vecs.push_back(vec_t'{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000, 31});

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].rm, 1'b0, got, lat);
            check($sformatf("dir%0d_result", i), got[31:0], vecs[i].res);
            check($sformatf("dir%0d_flags", i), got[36:32], vecs[i].fl);
            check($sformatf("dir%0d_latency", i), lat, vecs[i].lat);
        end

        run_op(32'h40C00000, 32'h40000000, 3'd0, 1'b1, got, lat);
        check("ignored_start_result", got, {5'b00000, 32'h40400000});
        check("ignored_start_latency", lat, 31);

        run_op(32'h3F800000, 32'h40400000, 3'd0, 1'b0, got, lat);
        io.operand_a = 32'h40C00000;
        io.operand_b = 32'h40000000;
        io.start = 1'b1;
        @(posedge clk);
        #1;
        io.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_busy", io.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", io.busy, 1'b0);
        check("abort_done", io.done, 1'b0);
        check("abort_result", io.result, 32'h0);
        check("abort_flags", {io.flag_nv, io.flag_dz, io.flag_of, io.flag_uf, io.flag_nx}, 5'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (io.done) dones++;
        end
        check("abort_no_done", dones, 0);

        for (int i = 0; i < 300; i++) begin
            a   = rnd_fp();
            b   = rnd_fp();
            rm  = 3'($urandom_range(0, 7));
            exp = ref_div(a, b, rm);
            run_op(a, b, rm, 1'b0, got, lat);
            check($sformatf("rand a=%h b=%h rm=%0d result", a, b, rm), got[31:0], exp[31:0]);
            check($sformatf("rand a=%h b=%h rm=%0d flags", a, b, rm), got[36:32], exp[36:32]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
